// File: rtl/clk_sched_pkg.sv
// Shared constants for the run-control clock scheduler: command opcodes,
// FSM state encoding and a small state decode helper.
package clk_sched_pkg;

    // Command opcodes presented on cmd_op.
    localparam logic [1:0] OP_RUN    = 2'b00;
    localparam logic [1:0] OP_HALT   = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_SETDIV = 2'b11;

    // Run-control FSM encoding (kept as plain constants for legacy tools).
    localparam logic [1:0] ST_HALTED = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;

    typedef logic [1:0] state_t;

    // True while the scheduler is issuing ticks (RUN or STEP).
    function automatic logic is_active(input state_t st);
        return st != ST_HALTED;
    endfunction

endpackage

// File: rtl/clk_sched_div.sv
// Programmable clock divider: owns the period counter, the active and
// pending divide ratios, the tick pulse, the cpu_clk square wave and the
// running tick count. The run-control FSM drives enable/clear.
module clk_sched_div
    import clk_sched_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,     // count this edge (RUN/STEP)
    input  logic             clear,      // restart the period from zero this edge
    input  logic             set_valid,  // new divide ratio accepted this edge
    input  logic [CNT_W-1:0] set_value,
    output logic             wrap,       // this edge ends a period and issues a tick
    output logic             tick,
    output logic             cpu_clk,
    output logic [CNT_W-1:0] tick_cnt
);

    // A ratio of zero is meaningless; it behaves as divide-by-one.
    localparam logic [CNT_W-1:0] DIV_RESET =
        (DEFAULT_DIV < 1) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_cur;
    logic [CNT_W-1:0] div_pend;
    logic             pend_valid;
    logic [CNT_W-1:0] count_eff;
    logic [CNT_W-1:0] set_norm;

    // A restart counts the accepting edge as the first cycle of a fresh
    // period, so the first tick lands exactly div cycles after acceptance.
    always_comb begin
        count_eff = clear ? '0 : count;
        set_norm  = (set_value == '0) ? CNT_W'(1) : set_value;
        wrap      = enable && (count_eff == div_cur - CNT_W'(1));
    end

    // Period counter, tick generation and divide-ratio bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            div_cur    <= DIV_RESET;
            div_pend   <= DIV_RESET;
            pend_valid <= 1'b0;
            tick       <= 1'b0;
            cpu_clk    <= 1'b0;
            tick_cnt   <= '0;
        end else if (enable) begin
            if (wrap) begin
                count    <= '0;
                tick     <= 1'b1;
                cpu_clk  <= ~cpu_clk;
                tick_cnt <= tick_cnt + CNT_W'(1);
                // Ratio changes only take effect on a period boundary.
                if (pend_valid) begin
                    div_cur <= div_pend;
                end
                pend_valid <= 1'b0;
            end else begin
                count <= count_eff + CNT_W'(1);
                tick  <= 1'b0;
            end
            // A later write overrides any value still waiting; one written on
            // a wrap edge waits for the following wrap.
            if (set_valid) begin
                div_pend   <= set_norm;
                pend_valid <= 1'b1;
            end
        end else begin
            // Stopped: no period in flight, so ratios apply immediately.
            count <= '0;
            tick  <= 1'b0;
            if (set_valid) begin
                div_cur <= set_norm;
            end else if (pend_valid) begin
                div_cur <= div_pend;
            end
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_sched.sv
// Run-control scheduler: decodes RUN/HALT/STEP/SET_DIV commands and the
// forced-halt input, sequences the HALTED/RUN/STEP FSM and step counter,
// and drives the divider that produces tick/cpu_clk/tick_cnt.
module clk_sched
    import clk_sched_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    output logic             cmd_ready,
    input  logic             halt_req,
    output logic             tick,
    output logic             cpu_clk,
    output logic             running,
    output logic             step_done,
    output logic [CNT_W-1:0] tick_cnt,
    output logic [1:0]       state_dbg
);

    // Command handshake: a command transfers on a rising edge where
    // cmd_valid && cmd_ready. cmd_ready depends only on the current state and
    // halt_req (never on cmd_valid); it is low throughout a STEP and whenever
    // a forced halt is requested, and the source must hold the command until
    // it transfers.

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] steps_left;
    logic [CNT_W-1:0] steps_next;
    logic [CNT_W-1:0] steps_eff;
    logic             done_next;

    logic accept;
    logic is_run;
    logic is_halt;
    logic is_set;
    logic step_zero;
    logic step_go;
    logic div_enable;
    logic div_clear;
    logic div_wrap;

    // Handshake and command decode.
    always_comb begin
        cmd_ready = (state != ST_STEP) && !halt_req;
        accept    = cmd_valid && cmd_ready;
        is_run    = accept && (cmd_op == OP_RUN);
        is_halt   = accept && (cmd_op == OP_HALT);
        is_set    = accept && (cmd_op == OP_SETDIV);
        step_zero = accept && (cmd_op == OP_STEP) && (cmd_arg == '0);
        step_go   = accept && (cmd_op == OP_STEP) && (cmd_arg != '0);
    end

    // Divider control: count while running or starting, restart on entry.
    always_comb begin
        div_enable = 1'b0;
        div_clear  = 1'b0;
        if (!halt_req) begin
            case (state)
                ST_HALTED: begin
                    if (is_run || step_go) begin
                        div_enable = 1'b1;
                        div_clear  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!(is_halt || step_zero)) begin
                        div_enable = 1'b1;
                        div_clear  = step_go;
                    end
                end
                ST_STEP: begin
                    div_enable = 1'b1;
                end
                default: begin
                    div_enable = 1'b0;
                end
            endcase
        end
    end

    // Next-state, step countdown and step completion.
    always_comb begin
        state_next = state;
        steps_next = steps_left;
        done_next  = 1'b0;
        steps_eff  = step_go ? cmd_arg : steps_left;
        if (halt_req) begin
            state_next = ST_HALTED;
            steps_next = '0;
        end else begin
            case (state)
                ST_HALTED: begin
                    if (is_run) begin
                        state_next = ST_RUN;
                    end else if (step_zero) begin
                        done_next = 1'b1;
                    end else if (step_go) begin
                        state_next = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (is_halt) begin
                        state_next = ST_HALTED;
                    end else if (step_zero) begin
                        state_next = ST_HALTED;
                        done_next  = 1'b1;
                    end else if (step_go) begin
                        state_next = ST_STEP;
                    end
                end
                ST_STEP: begin
                    state_next = ST_STEP;
                end
                default: begin
                    state_next = ST_HALTED;
                end
            endcase
            // Every tick issued while stepping (including one issued on the
            // accepting edge at divide-by-one) consumes a step.
            if ((state == ST_STEP || step_go) && div_wrap) begin
                if (steps_eff == CNT_W'(1)) begin
                    state_next = ST_HALTED;
                    steps_next = '0;
                    done_next  = 1'b1;
                end else begin
                    state_next = ST_STEP;
                    steps_next = steps_eff - CNT_W'(1);
                end
            end else if (step_go) begin
                steps_next = cmd_arg;
            end
        end
    end

    // FSM, step counter and step_done registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_HALTED;
            steps_left <= '0;
            step_done  <= 1'b0;
        end else begin
            state      <= state_next;
            steps_left <= steps_next;
            step_done  <= done_next;
        end
    end

    assign running   = is_active(state);
    assign state_dbg = state;

    clk_sched_div #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .enable    (div_enable),
        .clear     (div_clear),
        .set_valid (is_set),
        .set_value (cmd_arg),
        .wrap      (div_wrap),
        .tick      (tick),
        .cpu_clk   (cpu_clk),
        .tick_cnt  (tick_cnt)
    );

endmodule

// File: tb/tb_clk_sched.sv
// Bench for clk_sched: an event-scheduled reference model (next tick cycle,
// remaining steps, pending ratio) checked against the DUT every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_clk_sched;
    import clk_sched_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         cmd_valid;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic         cmd_ready;
    logic         halt_req;
    logic         tick;
    logic         cpu_clk;
    logic         running;
    logic         step_done;
    logic [W-1:0] tick_cnt;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    clk_sched #(.CNT_W(W), .DEFAULT_DIV(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_ready (cmd_ready),
        .halt_req  (halt_req),
        .tick      (tick),
        .cpu_clk   (cpu_clk),
        .running   (running),
        .step_done (step_done),
        .tick_cnt  (tick_cnt),
        .state_dbg (state_dbg)
    );

    // Clock and reset defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the scheduler is described by when the next tick is
    // due rather than by a counter.
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    int           m_mode;
    longint       m_div;
    longint       m_pend;
    longint       m_next;
    longint       m_steps;
    longint       cyc;
    logic [W-1:0] m_cnt;
    logic         m_cpu;
    logic         m_tick;
    logic         m_done;

    task automatic m_apply_pend();
        if (m_pend != 0) begin
            m_div  = m_pend;
            m_pend = 0;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        logic acc;
        longint d;
        if (reset) begin
            m_mode = M_HALT; m_div = 1; m_pend = 0; m_next = 0; m_steps = 0;
            m_cnt = '0; m_cpu = 1'b0; m_tick = 1'b0; m_done = 1'b0;
        end else begin
            cyc++;
            m_tick = 1'b0;
            m_done = 1'b0;
            acc = cmd_valid && (m_mode != M_STEP) && !halt_req;
            if (halt_req) begin
                m_mode  = M_HALT;
                m_steps = 0;
                m_apply_pend();
            end else begin
                if (acc) begin
                    case (cmd_op)
                        OP_RUN: if (m_mode == M_HALT) begin
                            m_mode = M_RUN;
                            m_next = cyc + m_div - 1;
                        end
                        OP_HALT: begin
                            m_mode = M_HALT;
                            m_apply_pend();
                        end
                        OP_STEP: if (cmd_arg == 0) begin
                            m_mode = M_HALT;
                            m_done = 1'b1;
                            m_apply_pend();
                        end else begin
                            m_mode  = M_STEP;
                            m_steps = longint'(cmd_arg);
                            m_next  = cyc + m_div - 1;
                        end
                        default: ;
                    endcase
                end
                if (m_mode != M_HALT && cyc == m_next) begin
                    m_tick = 1'b1;
                    m_cnt  = m_cnt + 1;
                    m_cpu  = !m_cpu;
                    m_apply_pend();
                    m_next = cyc + m_div;
                    if (m_mode == M_STEP) begin
                        m_steps--;
                        if (m_steps == 0) begin
                            m_mode = M_HALT;
                            m_done = 1'b1;
                        end
                    end
                end
                if (acc && cmd_op == OP_SETDIV) begin
                    d = (cmd_arg == 0) ? 1 : longint'(cmd_arg);
                    if (m_mode == M_HALT) m_div = d;
                    else m_pend = d;
                end
            end
        end
    end

    // Scoreboard compare, mid-cycle, every cycle.
    always @(negedge clk) begin
        check("tick", tick, m_tick);
        check("cpu_clk", cpu_clk, m_cpu);
        check("tick_cnt", tick_cnt, m_cnt);
        check("running", running, (m_mode != M_HALT));
        check("step_done", step_done, m_done);
        check("cmd_ready", cmd_ready, (m_mode != M_STEP) && !halt_req);
    end

    // Driver tasks: all called just after a rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_arg   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        cyc = 0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_RUN; cmd_arg = '0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_tick", tick, 0);
        check("rst_cpu_clk", cpu_clk, 0);
        check("rst_running", running, 0);
        check("rst_tick_cnt", tick_cnt, 0);
        check("rst_ready", cmd_ready, 1);

        // RUN at divide-by-one: a tick every cycle from the accepting edge.
        send(OP_RUN, 0);
        check("t1_first_tick", tick, 1);
        check("t1_first_cpu", cpu_clk, 1);
        wait_cycles(9);
        check("t1_cnt10", tick_cnt, 10);
        check("t1_cpu_even", cpu_clk, 0);
        send(OP_HALT, 0);
        check("t1_halt_notick", tick, 0);
        check("t1_halt_cnt", tick_cnt, 10);

        // SET_DIV 5 while halted, then STEP 3.
        do_reset();
        send(OP_SETDIV, 5);
        send(OP_STEP, 3);
        check("t2_step_busy", cmd_ready, 0);
        wait_cycles(4);
        check("t2_tick1", tick, 1);
        wait_cycles(5);
        check("t2_tick2", tick, 1);
        check("t2_no_done_early", step_done, 0);
        wait_cycles(5);
        check("t2_tick3", tick, 1);
        check("t2_done", step_done, 1);
        check("t2_stopped", running, 0);
        check("t2_cnt", tick_cnt, 3);
        check("t2_cpu", cpu_clk, 1);
        wait_cycles(1);
        check("t2_done_once", step_done, 0);

        // RUN at 4, retune to 2 mid-period.
        send(OP_SETDIV, 4);
        send(OP_RUN, 0);
        wait_cycles(5);
        send(OP_SETDIV, 2);
        wait_cycles(1);
        check("t3_full_period", tick, 1);
        wait_cycles(1);
        check("t3_gap", tick, 0);
        wait_cycles(1);
        check("t3_new_period", tick, 1);
        wait_cycles(2);
        check("t3_new_period2", tick, 1);
        send(OP_HALT, 0);
        check("t3_cnt", tick_cnt, 7);

        // STEP 10 at 3, forced halt after the 4th tick.
        do_reset();
        send(OP_SETDIV, 3);
        send(OP_STEP, 10);
        wait_cycles(11);
        check("t4_tick4", tick, 1);
        check("t4_cnt4", tick_cnt, 4);
        halt_req = 1'b1;
        @(posedge clk);
        #1;
        halt_req = 1'b0;
        check("t4_halt_notick", tick, 0);
        wait_cycles(10);
        check("t4_cnt_final", tick_cnt, 4);
        check("t4_stopped", running, 0);

        // STEP 0, SET_DIV 0, RUN, STEP 2 from RUN.
        send(OP_STEP, 0);
        check("t5_step0_done", step_done, 1);
        check("t5_step0_notick", tick, 0);
        wait_cycles(1);
        check("t5_step0_once", step_done, 0);
        send(OP_SETDIV, 0);
        send(OP_RUN, 0);
        check("t5_div1_tick", tick, 1);
        wait_cycles(2);
        check("t5_cnt", tick_cnt, 7);
        send(OP_STEP, 2);
        check("t5_step_first", tick, 1);
        wait_cycles(1);
        check("t5_step_last", tick, 1);
        check("t5_step_done", step_done, 1);
        check("t5_cnt2", tick_cnt, 9);

        // Forced halt beats a simultaneous command.
        halt_req = 1'b1; cmd_valid = 1'b1; cmd_op = OP_RUN;
        #1;
        check("t5_ready_blocked", cmd_ready, 0);
        @(posedge clk);
        #1;
        halt_req = 1'b0; cmd_valid = 1'b0;
        check("t5_not_started", running, 0);
        wait_cycles(2);
        check("t5_still_idle", tick, 0);

        // Asynchronous reset mid-RUN at divide-by-7.
        send(OP_SETDIV, 7);
        send(OP_RUN, 0);
        wait_cycles(14);
        check("t6_cnt", tick_cnt, 11);
        check("t6_cpu", cpu_clk, 1);
        check("t6_running", running, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_tick_cnt", tick_cnt, 0);
        check("t6_async_cpu", cpu_clk, 0);
        check("t6_async_running", running, 0);
        check("t6_async_tick", tick, 0);
        check("t6_async_done", step_done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cycles(3);
        check("t6_idle_after", tick_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
